cond_logic: RTL

COND_LOGIC -- requirements
Module: cond_logic

---
 rtl/cond_pkg.sv | 37 +++
 rtl/cond_logic_if.sv | 29 ++
 rtl/cond_check.sv | 43 ++++
 rtl/cond_logic.sv | 49 ++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for ARM condition evaluation and flag storage.
package cond_pkg;

  localparam int unsigned COND_W  = 4;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLAGW_W = 2;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Bit positions inside FlagW.
  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder/ALU-facing bundle of the condition logic block.
interface cond_logic_if;
  import cond_pkg::*;

  logic [COND_W-1:0]  Cond;
  logic [FLAGS_W-1:0] ALUFlags;
  logic [FLAGW_W-1:0] FlagW;
  logic               PCS;
  logic               RegW;
  logic               MemW;
  logic               NoWrite;
  logic               en;
  logic               PCSrc;
  logic               RegWrite;
  logic               MemWrite;
  logic               CondEx;
  logic [FLAGS_W-1:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, en,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, en,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

endinterface

// File: rtl/cond_check.sv
// Combinational condition-field evaluation against the stored flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [COND_W-1:0]  cond,
  input  logic [FLAGS_W-1:0] flags,
  output logic               cond_ex
);

  logic n, z, c, v;
  logic ge;

  assign n  = flags[FLAG_N];
  assign z  = flags[FLAG_Z];
  assign c  = flags[FLAG_C];
  assign v  = flags[FLAG_V];
  assign ge = (n == v);

  // Decode the 16 condition codes.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_t'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c && !z;
      COND_LS: cond_ex = !c || z;
      COND_GE: cond_ex = ge;
      COND_LT: cond_ex = !ge;
      COND_GT: cond_ex = !z && ge;
      COND_LE: cond_ex = z || !ge;
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Condition logic: flag register, condition check and write-strobe gating.
module cond_logic
  import cond_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [FLAGS_W-1:0] flags_q;
  logic               cond_ex;
  logic               wr_nz;
  logic               wr_cv;

  // Condition is judged only on the registered flags, never on ALUFlags.
  cond_check u_cond_check (
    .cond    (bus.Cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  // Flag halves update only when the stage advances and the instruction executes.
  assign wr_nz = bus.en && cond_ex && bus.FlagW[FLAGW_NZ];
  assign wr_cv = bus.en && cond_ex && bus.FlagW[FLAGW_CV];

  // Flag register; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else begin
      if (wr_nz) begin
        flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
      end
      if (wr_cv) begin
        flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
        flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
      end
    end
  end

  // Zero-latency gated strobes; NoWrite only suppresses the register write.
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS  && cond_ex;
  assign bus.MemWrite = bus.MemW && cond_ex;
  assign bus.RegWrite = bus.RegW && cond_ex && !bus.NoWrite;
  assign bus.Flags    = flags_q;

endmodule
